sccb_responder: RTL

- SCCB target (camera-side) model that receives the 3-phase write and 2-phase write / 2-phase read transactions generated by the team's SCCB initiator.
- Used as the camera stand-in in system simulation and as an on-FPGA register-port bridge.
- Decodes START/STOP, device ID, sub-address and data on SIOC/SIOD.
- Emits a register-write strobe, serves read data from a register port, and drives ACK and read bits through an open-drain enable.

---
 rtl/sccb_responder_if.sv | 38 +++
 rtl/sccb_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sccb_responder_if.sv
`timescale 1ns/1ps
// Bus-side and register-port signals of the SCCB responder.
// The slave modport is the camera-side target; master is the initiator/system side.
interface sccb_responder_if;
    logic       SIOC;
    logic       SIOD;
    logic       SIOD_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  SIOC,
        input  SIOD,
        input  rd_data,
        output SIOD_oe,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        output busy
    );

    modport master (
        output SIOC,
        output SIOD,
        output rd_data,
        input  SIOD_oe,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        input  busy
    );
endinterface

// File: rtl/sccb_responder.sv
`timescale 1ns/1ps
// SCCB target: decodes START/STOP, device ID, sub-address and data on SIOC/SIOD,
// strobes register writes and serves register reads through an open-drain enable.
module sccb_responder #(
    parameter logic [7:0] DEVICE_ADDR = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sccb_responder_if.slave bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ID       = 4'd1;
    localparam logic [3:0] S_ID_ACK   = 4'd2;
    localparam logic [3:0] S_SUB      = 4'd3;
    localparam logic [3:0] S_SUB_ACK  = 4'd4;
    localparam logic [3:0] S_DATA     = 4'd5;
    localparam logic [3:0] S_DATA_ACK = 4'd6;
    localparam logic [3:0] S_RD_BYTE  = 4'd7;
    localparam logic [3:0] S_RD_NA    = 4'd8;
    localparam logic [3:0] S_IGNORE   = 4'd9;

    logic [SYNC_STAGES-1:0] sioc_sync;
    logic [SYNC_STAGES-1:0] siod_sync;
    logic                   sioc_q;
    logic                   siod_q;

    logic       sioc_s;
    logic       siod_s;
    logic       sioc_rise;
    logic       sioc_fall;
    logic       start_cond;
    logic       stop_cond;
    logic       bit_sample;
    logic [7:0] byte_in;

    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       rd_mode;
    logic       siod_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic       busy;

    // Synchronizers and the previous-level copies preset to 1: a released bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_sync <= '1;
            siod_sync <= '1;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each stage sample its neighbour's pre-edge value.
            sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], bus.SIOC};
            siod_sync <= {siod_sync[SYNC_STAGES-2:0], bus.SIOD};
            sioc_q    <= sioc_s;
            siod_q    <= siod_s;
        end
    end

    assign sioc_s    = sioc_sync[SYNC_STAGES-1];
    assign siod_s    = siod_sync[SYNC_STAGES-1];
    assign sioc_rise = sioc_s & ~sioc_q;
    assign sioc_fall = ~sioc_s & sioc_q;

    // START/STOP qualify on the previous SIOC level; a bit landing with a SIOD change is dropped.
    assign start_cond = sioc_q & siod_q & ~siod_s;
    assign stop_cond  = sioc_q & ~siod_q & siod_s;
    assign bit_sample = sioc_rise & (siod_s == siod_q);
    assign byte_in    = {shift_reg[6:0], siod_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rd_mode   <= 1'b0;
            siod_oe   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_addr   <= '0;
            busy      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (stop_cond) begin
                state   <= S_IDLE;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
            end else if (start_cond) begin
                state   <= S_ID;
                bit_cnt <= '0;
                siod_oe <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_ID, S_SUB, S_DATA: begin
                        if (bit_sample) begin
                            shift_reg <= byte_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd8;
                                if (state == S_ID) begin
                                    if (byte_in == DEVICE_ADDR) begin
                                        rd_mode <= 1'b0;
                                        state   <= S_ID_ACK;
                                    end else if (byte_in == (DEVICE_ADDR | 8'h01)) begin
                                        rd_mode <= 1'b1;
                                        state   <= S_ID_ACK;
                                    end else begin
                                        state <= S_IGNORE;
                                    end
                                end else if (state == S_SUB) begin
                                    rd_addr <= byte_in;
                                    state   <= S_SUB_ACK;
                                end else begin
                                    wr_addr <= rd_addr;
                                    wr_data <= byte_in;
                                    wr_en   <= 1'b1;
                                    state   <= S_DATA_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // First fall after the 8th bit opens the ACK slot, the next one closes it.
                    S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
                        if (sioc_fall) begin
                            if (!siod_oe) begin
                                siod_oe <= 1'b1;
                            end else begin
                                siod_oe <= 1'b0;
                                bit_cnt <= '0;
                                case (state)
                                    S_ID_ACK: begin
                                        if (rd_mode) begin
                                            state     <= S_RD_BYTE;
                                            shift_reg <= bus.rd_data;
                                            siod_oe   <= ~bus.rd_data[7];
                                        end else begin
                                            state <= S_SUB;
                                        end
                                    end
                                    S_SUB_ACK: state <= S_DATA;
                                    default:   state <= S_IGNORE;
                                endcase
                            end
                        end
                    end

                    S_RD_BYTE: begin
                        if (sioc_fall) begin
                            if (bit_cnt == 4'd7) begin
                                siod_oe <= 1'b0;
                                bit_cnt <= 4'd8;
                                state   <= S_RD_NA;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                siod_oe   <= ~shift_reg[6];
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_RD_NA: begin
                        if (sioc_rise) begin
                            bit_cnt <= '0;
                            state   <= S_IGNORE;
                        end
                    end

                    S_IGNORE: siod_oe <= 1'b0;

                    default: siod_oe <= 1'b0;
                endcase
            end
        end
    end

    assign bus.SIOD_oe = siod_oe;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.rd_addr = rd_addr;
    assign bus.busy    = busy;

endmodule
